// File: rtl/mem_arbiter_2to1_if.sv
// Mem_ift memory port: one read channel (ren/raddr -> rvalid/rdata) and one write channel
// (wen/waddr/wdata/wmask -> wvalid). Master drives requests, Slave returns valid pulses.
interface Mem_ift #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                    ren;
  logic [ADDR_WIDTH-1:0]   raddr;
  logic                    wen;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wmask;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    wvalid;

  modport Master (
    output ren, raddr, wen, waddr, wdata, wmask,
    input  rvalid, rdata, wvalid
  );

  modport Slave (
    input  ren, raddr, wen, waddr, wdata, wmask,
    output rvalid, rdata, wvalid
  );
endinterface

// File: rtl/mem_arbiter_2to1.sv
// Two-master to one-slave Mem_ift arbiter: one whole transaction at a time, round-robin on contention.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN (sticky err, all-ones read data on expiry).
module mem_arbiter_2to1 #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic   clk,
  input  logic   rst,
  Mem_ift.Slave  m0,
  Mem_ift.Slave  m1,
  Mem_ift.Master s,
  output logic   err
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_arbiter_2to1: TIMEOUT must be at least 1");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("mem_arbiter_2to1: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   rr_q, rr_d;
  logic   grant;
  logic   timeout_hit;

  logic [1:0]            m_ren, m_wen, m_req;
  logic [1:0]            m_rvalid, m_wvalid;
  logic [ADDR_WIDTH-1:0] m_raddr [2];
  logic [ADDR_WIDTH-1:0] m_waddr [2];
  logic [DATA_WIDTH-1:0] m_wdata [2];
  logic [MASK_WIDTH-1:0] m_wmask [2];
  logic [DATA_WIDTH-1:0] m_rdata [2];

  // Index both masters by number so the owner bit can select directly.
  assign m_ren      = {m1.ren, m0.ren};
  assign m_wen      = {m1.wen, m0.wen};
  assign m_req      = m_ren | m_wen;
  assign m_raddr[0] = m0.raddr;
  assign m_raddr[1] = m1.raddr;
  assign m_waddr[0] = m0.waddr;
  assign m_waddr[1] = m1.waddr;
  assign m_wdata[0] = m0.wdata;
  assign m_wdata[1] = m1.wdata;
  assign m_wmask[0] = m0.wmask;
  assign m_wmask[1] = m1.wmask;

  assign m0.rvalid = m_rvalid[0];
  assign m0.rdata  = m_rdata[0];
  assign m0.wvalid = m_wvalid[0];
  assign m1.rvalid = m_rvalid[1];
  assign m1.rdata  = m_rdata[1];
  assign m1.wvalid = m_wvalid[1];

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    grant      = rr_q;
    s.ren      = 1'b0;
    s.raddr    = '0;
    s.wen      = 1'b0;
    s.waddr    = '0;
    s.wdata    = '0;
    s.wmask    = '0;
    m_rvalid   = '0;
    m_wvalid   = '0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;

    unique case (state_q)
      IDLE: begin
        grant = (m_req == 2'b11) ? rr_q : m_req[1];
        if (m_req != 2'b00) begin
          owner_d = grant;
          // A write takes precedence; a concurrent read is granted separately later.
          state_d = m_wen[grant] ? WRITE : READ;
        end
      end

      READ: begin
        if (timeout_hit) begin
          m_rvalid[owner_q] = 1'b1;
          m_rdata[owner_q]  = '1;
          state_d           = IDLE;
          rr_d              = ~owner_q;
        end else begin
          s.ren   = m_ren[owner_q];
          s.raddr = m_raddr[owner_q];
          if (s.rvalid) begin
            m_rvalid[owner_q] = 1'b1;
            m_rdata[owner_q]  = s.rdata;
            state_d           = IDLE;
            rr_d              = ~owner_q;
          end
        end
      end

      WRITE: begin
        if (timeout_hit) begin
          m_wvalid[owner_q] = 1'b1;
          state_d           = IDLE;
          rr_d              = ~owner_q;
        end else begin
          s.wen   = m_wen[owner_q];
          s.waddr = m_waddr[owner_q];
          s.wdata = m_wdata[owner_q];
          s.wmask = m_wmask[owner_q];
          if (s.wvalid) begin
            m_wvalid[owner_q] = 1'b1;
            state_d           = IDLE;
            rr_d              = ~owner_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_WIDTH = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  assign timeout_hit = (state_q != IDLE) && (cnt_q == CNT_WIDTH'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (timeout_hit) begin
      cnt_d = '0;
      err_d = 1'b1;
    end else if (!((state_q == READ && s.rvalid) || (state_q == WRITE && s.wvalid))) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Randomized bench for mem_arbiter_2to1: two master BFMs, a slave BFM with random latency and
// spurious pulses, and a transaction-level grant/response predictor.
module tb_mem_arbiter_2to1;

  localparam int AW = 64;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst;
  logic err;

  always #5 clk = ~clk;

  Mem_ift #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
  Mem_ift #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
  Mem_ift #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();

  mem_arbiter_2to1 #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m0 (m0_if),
    .m1 (m1_if),
    .s  (s_if),
    .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // master BFM state
  bit          pr [2];
  bit          pw [2];
  bit          drop [2];
  logic [63:0] ra [2];
  logic [63:0] wa [2];
  logic [63:0] wd [2];
  logic [7:0]  wm [2];
  bit          en_rand;

  // slave BFM state
  bit          silent;
  bit          sv_r, sv_w;
  int          slv_cnt, slv_lat;
  logic [63:0] next_rd, exp_rd;

  // transaction-level predictor
  bit mbusy, mown, mwrite, mrr;

  task automatic drive_masters();
    int k;
    for (int i = 0; i < 2; i++) begin
      if (drop[i]) begin
        drop[i] = 1'b0;
      end else if (!pr[i] && !pw[i] && en_rand && $urandom_range(0, 3) == 0) begin
        k     = $urandom_range(0, 2);
        ra[i] = {$urandom, $urandom};
        wa[i] = {$urandom, $urandom};
        wd[i] = {$urandom, $urandom};
        wm[i] = 8'($urandom);
        pr[i] = (k != 1);
        pw[i] = (k != 0);
      end
    end
    m0_if.ren = pr[0]; m0_if.raddr = ra[0]; m0_if.wen = pw[0];
    m0_if.waddr = wa[0]; m0_if.wdata = wd[0]; m0_if.wmask = wm[0];
    m1_if.ren = pr[1]; m1_if.raddr = ra[1]; m1_if.wen = pw[1];
    m1_if.waddr = wa[1]; m1_if.wdata = wd[1]; m1_if.wmask = wm[1];
  endtask

  task automatic drive_slave();
    bit sr, sw;
    sr = s_if.ren;
    sw = s_if.wen;
    sv_r = 1'b0;
    sv_w = 1'b0;
    s_if.rdata = {$urandom, $urandom};
    if (silent) begin
      slv_cnt = 0;
    end else if (sr || sw) begin
      if (slv_cnt >= slv_lat) begin
        if (sr) begin
          sv_r = 1'b1;
          s_if.rdata = next_rd;
          exp_rd = next_rd;
          next_rd = {$urandom, $urandom};
        end else begin
          sv_w = 1'b1;
        end
        slv_cnt = 0;
        slv_lat = $urandom_range(0, 3);
      end else begin
        slv_cnt++;
        if ($urandom_range(0, 7) == 0) begin
          if (sr) sv_w = 1'b1;
          else    sv_r = 1'b1;
        end
      end
    end else begin
      slv_cnt = 0;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) sv_r = 1'b1;
        else                           sv_w = 1'b1;
      end
    end
    s_if.rvalid = sv_r;
    s_if.wvalid = sv_w;
  endtask

  task automatic check_cycle();
    logic [1:0]  erv, ewv;
    logic [63:0] er [2];
    bit          done, q0, q1;
    erv = '0; ewv = '0; er[0] = '0; er[1] = '0; done = 1'b0;
    if (!mbusy) begin
      check("s_req_idle", {62'b0, s_if.ren, s_if.wen}, 64'd0);
      check("s_bus_idle", s_if.raddr | s_if.waddr | s_if.wdata | {56'b0, s_if.wmask}, 64'd0);
    end else if (mwrite) begin
      check("s_req_wr", {62'b0, s_if.ren, s_if.wen}, 64'd1);
      check("s_waddr", s_if.waddr, wa[mown]);
      check("s_wdata", s_if.wdata, wd[mown]);
      check("s_wmask", {56'b0, s_if.wmask}, {56'b0, wm[mown]});
      check("s_raddr_wr", s_if.raddr, 64'd0);
      done = sv_w;
      ewv[mown] = done;
    end else begin
      check("s_req_rd", {62'b0, s_if.ren, s_if.wen}, 64'd2);
      check("s_raddr", s_if.raddr, ra[mown]);
      check("s_wbus_rd", s_if.waddr | s_if.wdata | {56'b0, s_if.wmask}, 64'd0);
      done = sv_r;
      erv[mown] = done;
      if (done) er[mown] = exp_rd;
    end
    check("m_rvalid", {62'b0, m1_if.rvalid, m0_if.rvalid}, {62'b0, erv});
    check("m_wvalid", {62'b0, m1_if.wvalid, m0_if.wvalid}, {62'b0, ewv});
    if (!mbusy || erv[0] || mown)  check("m0_rdata", m0_if.rdata, er[0]);
    if (!mbusy || erv[1] || !mown) check("m1_rdata", m1_if.rdata, er[1]);
    check("err", {63'b0, err}, 64'd0);

    if (!mbusy) begin
      q0 = pr[0] | pw[0];
      q1 = pr[1] | pw[1];
      if (q0 || q1) begin
        mown   = (q0 && q1) ? mrr : q1;
        mwrite = pw[mown];
        mbusy  = 1'b1;
      end
    end else if (done) begin
      if (mwrite) pw[mown] = 1'b0;
      else        pr[mown] = 1'b0;
      drop[mown] = 1'b1;
      mrr   = ~mown;
      mbusy = 1'b0;
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    #1 drive_masters();
    #1 drive_slave();
    #1 check_cycle();
  endtask

  task automatic clear_bfms();
    for (int i = 0; i < 2; i++) begin
      pr[i] = 1'b0; pw[i] = 1'b0; drop[i] = 1'b0;
      ra[i] = '0; wa[i] = '0; wd[i] = '0; wm[i] = '0;
    end
    m0_if.ren = 1'b0; m0_if.raddr = '0; m0_if.wen = 1'b0;
    m0_if.waddr = '0; m0_if.wdata = '0; m0_if.wmask = '0;
    m1_if.ren = 1'b0; m1_if.raddr = '0; m1_if.wen = 1'b0;
    m1_if.waddr = '0; m1_if.wdata = '0; m1_if.wmask = '0;
    s_if.rvalid = 1'b0; s_if.wvalid = 1'b0; s_if.rdata = '0;
    sv_r = 1'b0; sv_w = 1'b0;
    slv_cnt = 0; slv_lat = 1;
    mbusy = 1'b0; mrr = 1'b0; mown = 1'b0; mwrite = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_bfms();
    repeat (2) @(posedge clk);
    #1 check_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog no_finish got=running exp=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    bit found;
    int waited;
    rst = 1'b1;
    en_rand = 1'b0;
    silent = 1'b0;
    next_rd = 64'hCAFE;
    exp_rd = '0;
    apply_reset();

    // Directed opening: m0 read vs m1 write+read under contention, rr starts at m0.
    ra[0] = 64'h1000; pr[0] = 1'b1;
    wa[1] = 64'h20; wd[1] = 64'h1122_3344_5566_7788; wm[1] = 8'hFF; pw[1] = 1'b1;
    ra[1] = 64'h40; pr[1] = 1'b1;
    slv_lat = 3;
    repeat (25) run_cycle();

    en_rand = 1'b1;
    repeat (3000) run_cycle();

    // Reset asserted while a read is in flight.
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      run_cycle();
      if (mbusy && !mwrite) found = 1'b1;
    end
    check("found_read", {63'b0, found}, 64'd1);
    @(posedge clk);
    #1 drive_masters();
    silent = 1'b1;
    #1 drive_slave();
    rst = 1'b1;
    #1;
    check("midrst_sreq", {62'b0, s_if.ren, s_if.wen}, 64'd0);
    check("midrst_raddr", s_if.raddr, 64'd0);
    check("midrst_mvalid", {60'b0, m1_if.rvalid, m1_if.wvalid, m0_if.rvalid, m0_if.wvalid}, 64'd0);
    check("midrst_err", {63'b0, err}, 64'd0);
    silent = 1'b0;
    apply_reset();
    repeat (1000) run_cycle();

`ifdef MEM_ARB_TIMEOUT_EN
    apply_reset();
    en_rand = 1'b0;
    silent = 1'b1;
    ra[0] = 64'h1000; pr[0] = 1'b1;
    found = 1'b0;
    waited = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk);
      #1 drive_masters();
      #1 drive_slave();
      #1;
      if (m0_if.rvalid) begin
        found = 1'b1;
        check("to_rdata", m0_if.rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        check("to_sren", {63'b0, s_if.ren}, 64'd0);
        check("to_cycle", 64'(waited), 64'd8);
        pr[0] = 1'b0;
        drop[0] = 1'b1;
      end else if (s_if.ren) begin
        waited++;
      end
    end
    check("to_seen", {63'b0, found}, 64'd1);
    repeat (3) @(posedge clk);
    #1 check("to_err_sticky", {63'b0, err}, 64'd1);
    rst = 1'b1;
    #1 check("to_err_rst", {63'b0, err}, 64'd0);
    silent = 1'b0;
    apply_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
